// File: rtl/nco_phase_accumulator_pkg.sv
// Shared constants and wave-select encodings for the NCO and LFO blocks.
package nco_phase_accumulator_pkg;

    localparam int NCO_FREQ_W  = 20;
    localparam int NCO_PHASE_W = 24;
    localparam int NCO_OUT_W   = 12;

    typedef enum logic [1:0] {
        WAVE_OFF = 2'b00,
        WAVE_SAW = 2'b01,
        WAVE_SQR = 2'b10,
        WAVE_TRI = 2'b11
    } wave_t;

    // Unsigned midscale code for a sample of the given width.
    function automatic int midscale(input int w);
        return 1 << (w - 1);
    endfunction

    localparam int MIDSCALE = 1 << (NCO_OUT_W - 1);

endpackage

// File: rtl/nco_wave_shaper.sv
// Maps the top bits of a phase word to a saw, square or triangle sample.
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows the inputs continuously.
module nco_wave_shaper
    import nco_phase_accumulator_pkg::*;
#(
    parameter int OUT_W = NCO_OUT_W
) (
    input  logic [OUT_W-1:0] p,
    input  logic [1:0]       wave_sel,
    output logic [OUT_W-1:0] sample
);

    localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

    logic             m;
    logic [OUT_W-1:0] tri_up;

    assign m      = p[OUT_W-1];
    assign tri_up = {p[OUT_W-2:0], 1'b0};

    always_comb begin
        sample = MID;
        case (wave_t'(wave_sel))
            WAVE_OFF: sample = MID;
            WAVE_SAW: sample = p;
            WAVE_SQR: sample = m ? {OUT_W{1'b1}} : '0;
            WAVE_TRI: sample = m ? ~tri_up : tri_up;
            default:  sample = MID;
        endcase
    end

endmodule

// File: rtl/nco_phase_accumulator.sv
// Divides clk to a sample tick, accumulates the tuning word and shapes a waveform.
// Latency: sample_valid pulses two edges after each tick cycle; retunes apply from the following tick.
// Backpressure: none; one sample per CLK_DIV clocks, sample holds between valids.
module nco_phase_accumulator
    import nco_phase_accumulator_pkg::*;
#(
    parameter int CLK_DIV = 1042,
    parameter int FREQ_W  = NCO_FREQ_W,
    parameter int PHASE_W = NCO_PHASE_W,
    parameter int OUT_W   = NCO_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] freq_word,
    input  logic              freq_load,
    input  logic              phase_reset,
    input  logic [1:0]        wave_sel,
    output logic [OUT_W-1:0]  sample,
    output logic              sample_valid
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   div_cnt;
    logic [PHASE_W-1:0] phase;
    logic [FREQ_W-1:0]  active_freq;
    logic [FREQ_W-1:0]  pending_freq;
    logic               pend_f;
    logic               pend_r;
    logic               tick;
    logic               tick_d;
    logic [OUT_W-1:0]   shaped;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    nco_wave_shaper #(.OUT_W(OUT_W)) u_shaper (
        .p        (phase[PHASE_W-1 -: OUT_W]),
        .wave_sel (wave_sel),
        .sample   (shaped)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt      <= '0;
            phase        <= '0;
            active_freq  <= '0;
            pending_freq <= '0;
            pend_f       <= 1'b0;
            pend_r       <= 1'b0;
            tick_d       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            tick_d  <= tick;

            if (tick) begin
                // Phase advances with the word that was active for the whole
                // interval; a new word only takes over afterwards.
                if (phase_reset || pend_r) begin
                    phase <= '0;
                end else begin
                    phase <= phase + PHASE_W'(active_freq);
                end
                pend_r <= 1'b0;
                if (freq_load) begin
                    active_freq <= freq_word;
                end else if (pend_f) begin
                    active_freq <= pending_freq;
                end
                pend_f <= 1'b0;
            end else begin
                if (freq_load) begin
                    pending_freq <= freq_word;
                    pend_f       <= 1'b1;
                end
                if (phase_reset) begin
                    pend_r <= 1'b1;
                end
            end

            if (tick_d) begin
                sample       <= shaped;
                sample_valid <= 1'b1;
            end else begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/nco_phase_accumulator.md
Name: nco_phase_accumulator

Overview:
- Downstream consumer of the 20-bit frequency memory register output.
- Turns the held frequency tuning word into an audio-rate waveform sample stream.
- Divides the system clock down to a sample tick. On each tick it advances a phase accumulator by the active tuning word, then maps the phase to saw, square or triangle samples for the DAC/mixer stage.
- Output frequency = freq_word × fs / 2^PHASE_W.

Parameters:
- CLK_DIV, 1042: system clocks per sample tick (50 MHz to about 48 kHz). Minimum 2.
- FREQ_W, 20: tuning word width. Matches the frequency register output.
- PHASE_W, 24: phase accumulator width. Must be greater than FREQ_W.
- OUT_W, 12: sample width, unsigned.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- freq_word  in  FREQ_W  tuning word from the frequency register.
- freq_load  in  1  one-cycle strobe: capture freq_word.
- phase_reset  in  1  one-cycle strobe: zero the phase at the next tick (note retrigger).
- wave_sel  in  2  00 silence, 01 saw, 10 square, 11 triangle.
- sample  out  OUT_W  current waveform sample.
- sample_valid  out  1  one-cycle pulse when sample updates.

Behaviour:
- Reset (asynchronous, active-high): div_cnt, phase, active_freq, pending_freq, pend_f, pend_r, tick_d, sample and sample_valid all go to 0 immediately.
- Reset mid-operation discards any pending load or retrigger.
- Tick divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (div_cnt == CLK_DIV-1), high for exactly one cycle every CLK_DIV cycles.
- Frequency capture:
  - freq_load with no tick: pending_freq <= freq_word, pend_f <= 1.
  - Later loads before the tick overwrite; last one wins.
  - On a tick, the phase update uses the OLD active_freq.
  - Then active_freq <= freq_word if freq_load is high in that same cycle, else pending_freq if pend_f is set. pend_f clears.
  - New word affects the phase from the following tick onward. This gives glitch-free retuning.
- Phase update on tick:
  - phase_reset high that cycle, or pend_r set: phase <= 0, pend_r <= 0.
  - Otherwise phase <= (phase + active_freq) mod 2^PHASE_W. Zero-extend active_freq; carry out discarded.
- phase_reset not on a tick sets pend_r.
- active_freq = 0 freezes the phase. This is legal.
- Output stage:
  - tick_d <= tick.
  - When tick_d is high, sample is registered from the updated phase and wave_sel sampled that cycle, and sample_valid <= 1. Otherwise sample_valid <= 0.
  - Latency: sample_valid is high in the cycle starting 2 edges after the tick cycle.
  - sample holds between valids.
- Waveforms, with p = phase[PHASE_W-1 -: OUT_W] and m = p[OUT_W-1]:
  - 00 silence: 2^(OUT_W-1) (2048, midscale).
  - 01 saw: p.
  - 10 square: m ? 2^OUT_W-1 : 0.
  - 11 triangle: m ? ~{p[OUT_W-2:0],1'b0} : {p[OUT_W-2:0],1'b0}.
- Simultaneous events:
  - freq_load and phase_reset on the same tick: phase zeroed, new word active from the next tick.
  - freq_load held continuously: treated as a load every cycle. Legal.

Decomposition:
- Shared synth package holds:
  - FREQ_W and PHASE_W constants.
  - Wave select encodings WAVE_OFF/WAVE_SAW/WAVE_SQR/WAVE_TRI.
  - Midscale constant.
- One natural sub-module: nco_wave_shaper. Purely combinational phase-to-sample map, reused later by the LFO.
- Divider and accumulator stay in the top.

Test Plan (CLK_DIV=4, defaults otherwise):
1. Tick cadence: release rst, wave_sel=00 -> sample_valid one-cycle pulses exactly 4 clocks apart; sample=2048 on each.
2. Saw: freq_word=0x10000 + freq_load, wave_sel=01 -> first tick adds 0. Then saw samples 16, 32, 48, ...; wraps to 0 after 256 further ticks.
3. Square: freq_word=0x80000 -> samples 4095 for 16 valids, then 0 for 16, period 32 ticks.
4. Load timing: active 0x10000, load 0x20000 one cycle after a tick -> next valid step still +16, following steps +32. Repeat with load coincident with tick -> same result.
5. Retrigger and triangle: freq_word=0x40000, wave_sel=11, phase_reset mid-interval -> next sample 0. Then 128, 256, 384, ...; peak near 4094; descends after p crosses 2048.
6. Async reset: assert rst between clock edges mid-stream with pend_f set -> all outputs 0 immediately. After release, active_freq=0 and the saw stays at 0.
